// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
// Shared definitions for the multi-cycle RV32I control path:
//   - state_e        : sequencing FSM states (also driven out on the debug port)
//   - OP_*           : RV32I major opcodes recognised by the controller
//   - PCSEL_*        : encodings of the pc_sel mux control
//   - CAUSE_*        : trap cause codes
//   - is_legal_opcode: opcode legality check used in DECODE
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEM       = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_TRAP      = 3'd6
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] PCSEL_PLUS4 = 2'b00;
  localparam logic [1:0] PCSEL_REL   = 2'b01;
  localparam logic [1:0] PCSEL_JALR  = 2'b10;

  localparam logic CAUSE_ILLEGAL = 1'b0;
  localparam logic CAUSE_TIMEOUT = 1'b1;

  function automatic logic is_legal_opcode(input logic [6:0] op);
    logic legal;
    case (op)
      OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_AUIPC, OP_LUI, OP_JAL, OP_JALR: legal = 1'b1;
      default:                           legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/multicycle_controller_mem_timeout_counter.sv
// mem_timeout_counter
// Counts consecutive memory wait cycles and flags when the wait limit is hit.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : zero the count (not waiting, or memory answered this cycle)
//   enable     : a memory request is outstanding this cycle
//   limit      : number of wait cycles allowed; 0 disables the check
//   expired    : this cycle is the limit-th consecutive wait cycle
module mem_timeout_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH:0]   count_inc;

  // Extra bit so the increment can never alias back onto a small limit.
  assign count_inc = {1'b0, count_q} + (WIDTH + 1)'(1);

  // Flag combinationally on the cycle the count would reach the limit so the
  // FSM leaves after exactly `limit` wait cycles; clear (mem_ready) wins.
  assign expired = enable && !clear && (limit != '0) &&
                   (count_inc == {1'b0, limit});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_inc[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller
// Sequencing FSM for a multi-cycle RV32I core sharing one memory port between
// instruction fetch and load/store. Steps FETCH -> DECODE -> EXECUTE ->
// (MEM) -> (WRITEBACK) and emits the per-cycle enables.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   instr                      : instruction register (opcode = instr[6:0])
//   dec_*                      : decoder control bits, valid from DECODE on
//   branch_taken               : comparator result, used in EXECUTE
//   mem_ready                  : memory completes the access this cycle
//   mem_req/mem_we/mem_addr_sel: memory request, write strobe, address mux
//   ir_we, alu_out_we, rf_we   : IR latch, ALU result latch, register write
//   pc_we, pc_sel              : PC update enable and source select
//   trap, trap_cause           : sticky trap flag and its cause
//   instret                    : retired-instruction counter
//   state                      : current FSM state (debug)
module multicycle_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        dec_reg_write,
  input  logic        dec_mem_read,
  input  logic        dec_mem_write,
  input  logic        dec_branch,
  input  logic        dec_jump,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        alu_out_we,
  output logic        rf_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        trap,
  output logic        trap_cause,
  output logic [31:0] instret,
  output logic [2:0]  state
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(MEM_TIMEOUT);

  state_e      state_q;
  logic        trap_q;
  logic        trap_cause_q;
  logic [31:0] instret_q;

  logic [6:0]  opcode;
  logic        mem_wait_state;
  logic        timeout_expired;
  logic        unused_instr_bits;

  assign opcode            = instr[6:0];
  assign unused_instr_bits = ^instr[31:7];

  // Counter runs only while a request is outstanding; holding it clear in all
  // other states gives the "cleared on entry to FETCH/MEM" behaviour.
  assign mem_wait_state = (state_q == ST_FETCH) || (state_q == ST_MEM);

  mem_timeout_counter #(
    .WIDTH (CNT_W)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!mem_wait_state || mem_ready),
    .enable  (mem_wait_state),
    .limit   (TIMEOUT_LIMIT),
    .expired (timeout_expired)
  );

  // Moore decode of state plus qualifying inputs. Decoding straight from the
  // state register lets an asynchronous reset drop mem_req immediately.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    alu_out_we   = 1'b0;
    rf_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PCSEL_PLUS4;
    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
      end
      ST_EXECUTE: begin
        alu_out_we = 1'b1;
        if (dec_branch) begin
          pc_we  = 1'b1;
          pc_sel = branch_taken ? PCSEL_REL : PCSEL_PLUS4;
        end
      end
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = dec_mem_write;
        // A store retires as soon as memory accepts it.
        pc_we        = mem_ready && dec_mem_write;
      end
      ST_WRITEBACK: begin
        rf_we = dec_reg_write;
        pc_we = 1'b1;
        if (dec_jump) begin
          pc_sel = (opcode == OP_JALR) ? PCSEL_JALR : PCSEL_REL;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RESET;
      trap_q       <= 1'b0;
      trap_cause_q <= CAUSE_ILLEGAL;
      instret_q    <= 32'd0;
    end else begin
      // pc_we pulses exactly once per retired instruction.
      if (pc_we) begin
        instret_q <= instret_q + 32'd1;
      end
      case (state_q)
        ST_RESET: state_q <= ST_FETCH;
        ST_FETCH: begin
          if (mem_ready) begin
            state_q <= ST_DECODE;
          end else if (timeout_expired) begin
            state_q      <= ST_TRAP;
            trap_q       <= 1'b1;
            trap_cause_q <= CAUSE_TIMEOUT;
          end
        end
        ST_DECODE: begin
          if (is_legal_opcode(opcode)) begin
            state_q <= ST_EXECUTE;
          end else begin
            state_q      <= ST_TRAP;
            trap_q       <= 1'b1;
            trap_cause_q <= CAUSE_ILLEGAL;
          end
        end
        ST_EXECUTE: begin
          if (dec_branch) begin
            state_q <= ST_FETCH;
          end else if (dec_mem_read || dec_mem_write) begin
            state_q <= ST_MEM;
          end else begin
            state_q <= ST_WRITEBACK;
          end
        end
        ST_MEM: begin
          if (mem_ready) begin
            state_q <= dec_mem_write ? ST_FETCH : ST_WRITEBACK;
          end else if (timeout_expired) begin
            state_q      <= ST_TRAP;
            trap_q       <= 1'b1;
            trap_cause_q <= CAUSE_TIMEOUT;
          end
        end
        ST_WRITEBACK: state_q <= ST_FETCH;
        ST_TRAP:      state_q <= ST_TRAP;
        default:      state_q <= ST_RESET;
      endcase
    end
  end

  assign trap       = trap_q;
  assign trap_cause = trap_cause_q;
  assign instret    = instret_q;
  assign state      = state_q;

endmodule
